blend_weight_seq: RTL and testbench

BLEND_WEIGHT_SEQ -- requirements
Module: blend_weight_seq

---
 rtl/blend_weight_seq.sv | 207 ++++++++++++++++++++
 tb/tb_blend_weight_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blend_weight_seq.sv
// Blend weight sequencer.
// Turns a pixel difference and two thresholds into a pair of 8-bit
// blend weights (w_s, w_f).
// Differences outside the [th0, th1) window saturate immediately.
// Differences inside the window are interpolated with a restoring divider
// that is shared between the two weights. The divider produces one
// quotient bit per cycle.
module blend_weight_seq #(
  parameter int pixelBitWidth     = 12,
  parameter int thresholdBitWidth = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [pixelBitWidth:0]       diff,
  input  logic [thresholdBitWidth-1:0] blend_th0,
  input  logic [thresholdBitWidth-1:0] blend_th1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   w_s,
  output logic [7:0]                   w_f,
  output logic                         busy
);

  localparam int DW = pixelBitWidth + 1;
  localparam int TW = thresholdBitWidth;
  // Compare width: wide enough for both the difference and the thresholds,
  // plus one guard bit so the subtractions below cannot wrap.
  localparam int CW = ((DW > TW) ? DW : TW) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV_S,
    DIV_F,
    DONE
  } state_t;

  state_t          state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [7:0]      w_s_reg;
  logic [7:0]      w_f_reg;

  // Request captured on acceptance.
  logic [DW-1:0]   diff_reg;
  logic [TW-1:0]   th0_reg;
  logic [TW-1:0]   th1_reg;

  // Divider state.
  logic [TW-1:0]   d_reg;        // divisor th1-th0
  logic [TW-1:0]   rem_reg;      // partial remainder, always < d_reg
  logic [7:0]      dvd_low_reg;  // dividend bits still to be shifted in
  logic [6:0]      quo_reg;      // quotient bits produced so far
  logic [2:0]      cnt_reg;      // iteration counter
  logic            n_zero_reg;   // current numerator is zero, force result 0
  logic [7:0]      s_quo_reg;    // w_s result held while w_f is computed

  // Classification and numerator terms.
  logic [CW-1:0]   diff_ext;
  logic [CW-1:0]   th0_ext;
  logic [CW-1:0]   th1_ext;
  logic            lt;
  logic            ge;
  logic [TW-1:0]   n_s;
  logic [TW-1:0]   n_f;
  logic [TW-1:0]   d_calc;
  logic [TW-1:0]   load_n;
  logic [TW+7:0]   dvd_load;

  // Single divider iteration.
  logic [TW:0]     trial;
  logic [TW:0]     d_ext;
  logic            take;
  logic [TW-1:0]   rem_step;
  logic [7:0]      quo_step;

  // Compare against the zero-extended thresholds and form the numerators.
  always_comb begin
    diff_ext = CW'(diff_reg);
    th0_ext  = CW'(th0_reg);
    th1_ext  = CW'(th1_reg);
    lt       = (diff_ext < th0_ext);
    ge       = (diff_ext >= th1_ext);
    n_s      = TW'(th1_ext - diff_ext);
    n_f      = TW'(diff_ext - th0_ext);
    d_calc   = th1_reg - th0_reg;
    // CHECK loads the w_s numerator; the DIV_S exit loads the w_f numerator.
    load_n   = (state_reg == CHECK) ? n_s : n_f;
    dvd_load = {load_n, 8'h00} - (TW + 8)'(1);
  end

  // Restoring divider step: shift in one dividend bit, subtract if possible.
  always_comb begin
    trial    = {rem_reg, dvd_low_reg[7]};
    d_ext    = {1'b0, d_reg};
    take     = (trial >= d_ext);
    rem_step = take ? TW'(trial - d_ext) : trial[TW-1:0];
    quo_step = {quo_reg, take};
  end

  // Control FSM, divider datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      w_s_reg       <= '0;
      w_f_reg       <= '0;
      diff_reg      <= '0;
      th0_reg       <= '0;
      th1_reg       <= '0;
      d_reg         <= '0;
      rem_reg       <= '0;
      dvd_low_reg   <= '0;
      quo_reg       <= '0;
      cnt_reg       <= '0;
      n_zero_reg    <= 1'b0;
      s_quo_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_ready_reg && in_valid) begin
            diff_reg     <= diff;
            th0_reg      <= blend_th0;
            th1_reg      <= blend_th1;
            in_ready_reg <= 1'b0;
            state_reg    <= CHECK;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end

        CHECK: begin
          if (lt || ge) begin
            case ({ge, lt})
              2'b01:   begin w_s_reg <= 8'hFF; w_f_reg <= 8'h00; end
              2'b10:   begin w_s_reg <= 8'h00; w_f_reg <= 8'hFF; end
              default: begin w_s_reg <= 8'h00; w_f_reg <= 8'h00; end
            endcase
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            d_reg       <= d_calc;
            rem_reg     <= dvd_load[TW+7:8];
            dvd_low_reg <= dvd_load[7:0];
            quo_reg     <= '0;
            cnt_reg     <= '0;
            n_zero_reg  <= (load_n == '0);
            state_reg   <= DIV_S;
          end
        end

        DIV_S: begin
          rem_reg     <= rem_step;
          dvd_low_reg <= {dvd_low_reg[6:0], 1'b0};
          quo_reg     <= quo_step[6:0];
          cnt_reg     <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            s_quo_reg   <= n_zero_reg ? 8'h00 : quo_step;
            // Reload the divider with the w_f numerator.
            rem_reg     <= dvd_load[TW+7:8];
            dvd_low_reg <= dvd_load[7:0];
            quo_reg     <= '0;
            n_zero_reg  <= (load_n == '0);
            state_reg   <= DIV_F;
          end
        end

        DIV_F: begin
          rem_reg     <= rem_step;
          dvd_low_reg <= {dvd_low_reg[6:0], 1'b0};
          quo_reg     <= quo_step[6:0];
          cnt_reg     <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            w_s_reg       <= s_quo_reg;
            w_f_reg       <= n_zero_reg ? 8'h00 : quo_step;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign w_s       = w_s_reg;
  assign w_f       = w_f_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_blend_weight_seq.sv
// Directed testbench for blend_weight_seq.
// Each scenario task drives its own stimulus and checks the results
// against hand-computed expected values.
module tb_blend_weight_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] diff;
  logic [8:0]  blend_th0;
  logic [8:0]  blend_th1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  w_s;
  logic [7:0]  w_f;
  logic        busy;

  int errors = 0;
  int checks = 0;

  blend_weight_seq #(
    .pixelBitWidth(12),
    .thresholdBitWidth(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .diff(diff),
    .blend_th0(blend_th0),
    .blend_th1(blend_th1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .w_s(w_s),
    .w_f(w_f),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always terminates.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // Issues one request, scrambles the inputs after acceptance and returns the
  // observed latency (cycles after the acceptance edge, -1 on timeout) and
  // the weights. The result is then consumed with a one-cycle out_ready.
  task automatic do_req(input logic [12:0] d, input logic [8:0] t0, input logic [8:0] t1,
                        output int lat, output logic [7:0] ws, output logic [7:0] wf);
    int guard;
    @(negedge clk);
    in_valid  = 1'b1;
    diff      = d;
    blend_th0 = t0;
    blend_th1 = t1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    diff      = 13'($urandom);
    blend_th0 = 9'($urandom);
    blend_th1 = 9'($urandom);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    ws = w_s;
    wf = w_f;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("req diff=%0d th0=%0d th1=%0d -> w_s=%0d w_f=%0d latency=%0d",
             d, t0, t1, ws, wf, lat);
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    diff      = '0;
    blend_th0 = '0;
    blend_th1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (w_s !== 8'd0 || w_f !== 8'd0) begin
      errors++; $display("FAIL reset_weights: got %0d/%0d expected 0/0", w_s, w_f);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  task automatic test_interpolate();
    int lat;
    logic [7:0] ws, wf;
    do_req(13'd150, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL interp150_latency: got %0d expected 18", lat); end
    checks++;
    if (ws !== 8'd127 || wf !== 8'd127) begin
      errors++; $display("FAIL interp150_weights: got %0d/%0d expected 127/127", ws, wf);
    end
    do_req(13'd101, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'd253 || wf !== 8'd2) begin
      errors++; $display("FAIL interp101_weights: got %0d/%0d expected 253/2", ws, wf);
    end
    do_req(13'd11, 9'd10, 9'd13, lat, ws, wf);
    checks++;
    if (ws !== 8'd170 || wf !== 8'd85 || lat !== 18) begin
      errors++; $display("FAIL interp_d3: got %0d/%0d lat %0d expected 170/85 lat 18", ws, wf, lat);
    end
  endtask

  task automatic test_boundaries();
    int lat;
    logic [7:0] ws, wf;
    // diff == th0 gives a zero w_f numerator.
    do_req(13'd100, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'd255 || wf !== 8'd0 || lat !== 18) begin
      errors++; $display("FAIL edge_th0: got %0d/%0d lat %0d expected 255/0 lat 18", ws, wf, lat);
    end
    // Smallest divisor.
    do_req(13'd0, 9'd0, 9'd1, lat, ws, wf);
    checks++;
    if (ws !== 8'd255 || wf !== 8'd0) begin
      errors++; $display("FAIL edge_d1: got %0d/%0d expected 255/0", ws, wf);
    end
    // Largest divisor.
    do_req(13'd510, 9'd0, 9'd511, lat, ws, wf);
    checks++;
    if (ws !== 8'd0 || wf !== 8'd255) begin
      errors++; $display("FAIL edge_d511: got %0d/%0d expected 0/255", ws, wf);
    end
  endtask

  task automatic test_saturate();
    int lat;
    logic [7:0] ws, wf;
    do_req(13'd50, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'hFF || wf !== 8'h00 || lat !== 2) begin
      errors++; $display("FAIL sat_low: got %0d/%0d lat %0d expected 255/0 lat 2", ws, wf, lat);
    end
    do_req(13'd250, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'h00 || wf !== 8'hFF || lat !== 2) begin
      errors++; $display("FAIL sat_high: got %0d/%0d lat %0d expected 0/255 lat 2", ws, wf, lat);
    end
    do_req(13'd200, 9'd300, 9'd100, lat, ws, wf);
    checks++;
    if (ws !== 8'h00 || wf !== 8'h00 || lat !== 2) begin
      errors++; $display("FAIL sat_both: got %0d/%0d lat %0d expected 0/0 lat 2", ws, wf, lat);
    end
    // diff == th1 is at or above the upper threshold.
    do_req(13'd200, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'h00 || wf !== 8'hFF) begin
      errors++; $display("FAIL sat_eq_th1: got %0d/%0d expected 0/255", ws, wf);
    end
    // A difference wider than the thresholds.
    do_req(13'd4000, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'h00 || wf !== 8'hFF) begin
      errors++; $display("FAIL sat_wide_diff: got %0d/%0d expected 0/255", ws, wf);
    end
    // Equal thresholds must not divide.
    do_req(13'd100, 9'd100, 9'd100, lat, ws, wf);
    checks++;
    if (ws !== 8'h00 || wf !== 8'hFF || lat !== 2) begin
      errors++; $display("FAIL sat_eq_th: got %0d/%0d lat %0d expected 0/255 lat 2", ws, wf, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int bad;
    logic [7:0] ws0, wf0;
    // First request: interpolate 150 -> 127/127.
    @(negedge clk);
    in_valid  = 1'b1;
    diff      = 13'd150;
    blend_th0 = 9'd100;
    blend_th1 = 9'd200;
    while (!in_ready) @(negedge clk);
    @(posedge clk);
    #1;
    // Keep in_valid high with a second, saturating request pending.
    diff = 13'd50;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL bp_latency: got %0d expected 18", lat); end
    ws0 = w_s;
    wf0 = w_f;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_s !== ws0 || w_f !== wf0 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
        bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    checks++;
    if (ws0 !== 8'd127 || wf0 !== 8'd127) begin
      errors++; $display("FAIL bp_weights: got %0d/%0d expected 127/127", ws0, wf0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    $display("req diff=150 th0=100 th1=200 -> w_s=%0d w_f=%0d latency=%0d (held 10 cycles)", ws0, wf0, lat);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_ready: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
    // Second request is accepted on the very next edge.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || w_s !== 8'hFF || w_f !== 8'h00) begin
      errors++; $display("FAIL b2b_result: got valid=%b %0d/%0d expected 1 255/0", out_valid, w_s, w_f);
    end
    $display("req diff=50 th0=100 th1=200 -> w_s=%0d w_f=%0d (back-to-back)", w_s, w_f);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [7:0] ws, wf;
    @(negedge clk);
    in_valid  = 1'b1;
    diff      = 13'd150;
    blend_th0 = 9'd100;
    blend_th1 = 9'd200;
    while (!in_ready) @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Edge 1 enters DIV_S; after edge 4 the divider is in its 4th cycle.
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || w_s !== 8'd0 || w_f !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b ready=%b valid=%b w=%0d/%0d expected 0/0/0 0/0",
               busy, in_ready, out_valid, w_s, w_f);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_no_result: got %0d valid cycles expected 0", seen); end
    $display("reset mid-division: aborted request, out_valid cycles=%0d", seen);
    do_req(13'd150, 9'd100, 9'd200, lat, ws, wf);
    checks++;
    if (ws !== 8'd127 || wf !== 8'd127 || lat !== 18) begin
      errors++; $display("FAIL mid_recover: got %0d/%0d lat %0d expected 127/127 lat 18", ws, wf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_interpolate();
    test_boundaries();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
